// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST controller.
// Truth tables are indexed by {a,b}: bit i is the expected output for input i.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int NUM_VECTORS = 4;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_bist_ctrl.sv
// Exhaustive 4-vector BIST for an external 2-input gate.
// Each vector settles SETTLE_CYCLES cycles, then the output is checked once.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] truth_table,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
);

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_idx;
  logic [7:0] r_cnt;
  logic [3:0] r_tt;
  logic [3:0] r_fail;
  logic       r_pass;

  logic       w_go;
  logic       w_drive;
  logic [3:0] w_bit;
  logic [3:0] w_fail_new;

  assign w_go       = start && !abort;
  assign w_bit      = 4'b0001 << r_idx;
  assign w_fail_new = (dut_out != r_tt[r_idx])
                    ? (r_fail | w_bit) : r_fail;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (abort)                 w_next = S_IDLE;
        else if (r_cnt == CNT_LAST) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (abort)              w_next = S_IDLE;
        else if (r_idx == 2'd3) w_next = S_DONE;
        else                    w_next = S_SETTLE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Abort keeps the partial fail_vec but never reports a pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_tt   <= '0;
      r_fail <= '0;
      r_pass <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_tt   <= truth_table;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_fail <= '0;
            r_pass <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (abort) r_pass <= 1'b0;
          else       r_cnt  <= r_cnt + 8'd1;
        end
        S_CHECK: begin
          if (abort) begin
            r_pass <= 1'b0;
          end else begin
            r_fail <= w_fail_new;
            r_cnt  <= '0;
            if (r_idx == 2'd3) r_pass <= (w_fail_new == 4'd0);
            else               r_idx  <= r_idx + 2'd1;
          end
        end
        S_DONE: begin
          if (abort) r_pass <= 1'b0;
        end
        default: r_pass <= 1'b0;
      endcase
    end
  end

  assign w_drive  = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign dut_a    = w_drive & r_idx[1];
  assign dut_b    = w_drive & r_idx[0];
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign pass     = r_pass;
  assign fail_vec = r_fail;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: a cycle-count model of the run plus directed
// scenarios with literal expectations on completion time and results.
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;

  localparam int S   = 2;
  localparam int LAT = 4 * (S + 1) + 1;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] truth_table;
  logic       dut_a, dut_b, dut_out;
  logic       busy, done, pass;
  logic [3:0] fail_vec;

  int gate_mode;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  // 0: OR, 1: stuck-at-0, 2: XOR, 3: NAND
  function automatic logic gate_fn(input int m, input logic a, input logic b);
    case (m)
      0: return a | b;
      1: return 1'b0;
      2: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  assign dut_out = gate_fn(gate_mode, dut_a, dut_b);

  gate_bist_ctrl #(.SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .truth_table(truth_table),
    .dut_a(dut_a), .dut_b(dut_b), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .fail_vec(fail_vec)
  );

  // Model: m_n counts cycles since the edge that accepted start
  // (cycle 1 is the first after that edge). Vector v occupies
  // cycles v*(S+1)+1 .. v*(S+1)+S+1, its last one being the check.
  bit         m_active = 0;
  int         m_n = 0;
  logic [3:0] m_tt = '0;
  logic [3:0] m_fail = '0;
  logic       m_pass = 1'b0;

  function automatic int vidx(input int n);
    return (n - 1) / (S + 1);
  endfunction

  function automatic bit is_check(input int n);
    return (n >= 1) && (n < LAT) && ((n - 1) % (S + 1) == S);
  endfunction

  function automatic logic [3:0] upd_fail(input logic [3:0] f,
                                          input logic [3:0] tt,
                                          input int v, input int m);
    logic [3:0] r;
    logic [1:0] vi;
    r  = f;
    vi = 2'(v);
    if (gate_fn(m, vi[1], vi[0]) != tt[v]) r[v] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 0;
      m_n      <= 0;
      m_fail   <= '0;
      m_pass   <= 1'b0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active <= 1;
        m_n      <= 1;
        m_tt     <= truth_table;
        m_fail   <= '0;
        m_pass   <= 1'b0;
      end
    end else if (abort) begin
      m_active <= 0;
      m_pass   <= 1'b0;
    end else if (m_n == LAT) begin
      m_active <= 0;
    end else begin
      m_n <= m_n + 1;
      if (is_check(m_n)) begin
        m_fail <= upd_fail(m_fail, m_tt, vidx(m_n), gate_mode);
        if (vidx(m_n) == 3)
          m_pass <= (upd_fail(m_fail, m_tt, 3, gate_mode) == 4'd0);
      end
    end
  end

  logic [8:0] e_vec, a_vec;
  logic [1:0] e_ab;

  always_comb begin
    e_ab = 2'b00;
    if (m_active && m_n < LAT) e_ab = 2'(vidx(m_n));
    e_vec = {m_active, m_active && (m_n == LAT), m_pass, m_fail, e_ab};
    a_vec = {busy, done, pass, fail_vec, dut_a, dut_b};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (a_vec !== e_vec) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t actual busy,done,pass,fv,a,b=%b required=%b",
                 $time, a_vec, e_vec);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One run; st2/ab/rs give the cycle at which a second start (with a
  // changed truth table), an abort or a reset is asserted (0 = never).
  task automatic run(input string nm, input logic [3:0] tt, input int mode,
                     input int st2, input int ab, input int rs,
                     input int exp_done, input logic [3:0] exp_fv,
                     input logic exp_pass);
    int got;
    int ndone;
    gate_mode   = mode;
    truth_table = tt;
    start       = 1'b1;
    cyc();
    start = 1'b0;
    got   = 0;
    ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      start = (k == st2);
      abort = (k == ab);
      rst   = (k == rs);
      if (k == st2) truth_table = TT_AND;
      @(negedge clk);
      if (done) begin
        ndone++;
        if (got == 0) got = k;
      end
      if (ab != 0 && k == ab + 1) begin
        chk({nm, "_abort_busy"}, int'(busy), 0);
        chk({nm, "_abort_ab"}, int'({dut_a, dut_b}), 0);
        chk({nm, "_abort_pass"}, int'(pass), 0);
      end
      if (rs != 0 && k == rs + 1)
        chk({nm, "_rst_outs"},
            int'({busy, done, pass, fail_vec, dut_a, dut_b}), 0);
      cyc();
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    chk({nm, "_done_cycle"}, got, exp_done);
    chk({nm, "_done_count"}, ndone, (exp_done != 0) ? 1 : 0);
    chk({nm, "_fail_vec"}, int'(fail_vec), int'(exp_fv));
    chk({nm, "_pass"}, int'(pass), int'(exp_pass));
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    truth_table = '0;
    gate_mode   = 0;
    cyc();
    chk_en = 1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", int'({busy, done, pass, fail_vec, dut_a, dut_b}), 0);
    cyc();

    run("or_ok",      TT_OR,   0, 0, 0, 0, 13, 4'b0000, 1'b1);
    run("stuck0",     TT_OR,   1, 0, 0, 0, 13, 4'b1110, 1'b0);
    run("wrong_tt",   TT_AND,  0, 0, 0, 0, 13, 4'b0110, 1'b0);
    run("xor_ok",     TT_XOR,  2, 0, 0, 0, 13, 4'b0000, 1'b1);
    run("nand_vs_xor", TT_XOR, 3, 0, 0, 0, 13, 4'b0001, 1'b0);
    run("busy_start", TT_OR,   0, 6, 0, 0, 13, 4'b0000, 1'b1);
    run("abort5",     TT_OR,   0, 0, 5, 0, 0,  4'b0000, 1'b0);
    run("abort7",     TT_OR,   1, 0, 7, 0, 0,  4'b0010, 1'b0);
    run("nand_ok",    TT_NAND, 3, 0, 0, 0, 13, 4'b0000, 1'b1);

    // abort beats start in IDLE; previous results must survive
    truth_table = TT_OR;
    gate_mode   = 0;
    start       = 1'b1;
    abort       = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_start_idle_busy", int'(busy), 0);
    chk("abort_start_idle_pass", int'(pass), 1);
    cyc();

    run("rst7",       TT_OR,   1, 0, 0, 7, 0,  4'b0000, 1'b0);
    run("after_rst",  TT_OR,   0, 0, 0, 0, 13, 4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 2: cycles each input vector is held before the output is sampled; legal range 1..255.
REQ-002 SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begin a test run; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: cancel the current run.
REQ-007 SHALL have port truth_table, input, 4 bits: expected gate output, where bit i is the expected value for {a,b}=i.
REQ-008 SHALL have port dut_a, output, 1 bit: first input driven to the 2-input gate under test.
REQ-009 SHALL have port dut_b, output, 1 bit: second input driven to the 2-input gate under test.
REQ-010 SHALL have port dut_out, input, 1 bit: output of the gate under test.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: single-cycle pulse marking run completion.
REQ-013 SHALL have port pass, output, 1 bit: result of the last completed run.
REQ-014 SHALL have port fail_vec, output, 4 bits: bit i set if vector i mismatched in the last run.

Function
REQ-015 SHALL implement the states IDLE, SETTLE, CHECK and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch truth_table, set vec_idx=0, clear fail_vec, and enter SETTLE on the next edge.
REQ-017 dut_a SHALL equal vec_idx[1] and dut_b SHALL equal vec_idx[0] in SETTLE and CHECK; both SHALL be 0 in IDLE and DONE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles (counter 0..SETTLE_CYCLES-1) and then go to CHECK.
REQ-019 CHECK SHALL last one cycle: it SHALL set fail_vec[vec_idx] if dut_out differs from the latched truth_table[vec_idx].
REQ-020 From CHECK, if vec_idx<3 the block SHALL increment vec_idx and enter SETTLE; if vec_idx=3 it SHALL enter DONE.
REQ-021 DONE SHALL last one cycle with done=1, and SHALL set pass=1 exactly when the final fail_vec (including the vec_idx=3 result) is all zero; the next state SHALL be IDLE.
REQ-022 Latency: done SHALL assert 4*(SETTLE_CYCLES+1)+1 cycles after the edge that samples start (13 for the default).
REQ-023 pass and fail_vec SHALL hold their values until the next accepted start or reset.
REQ-024 start while busy SHALL be ignored; the latched truth_table SHALL remain unchanged for the whole run.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse, pass=0, and fail_vec holding its partial value.
REQ-026 abort and start in the same cycle in IDLE: abort SHALL win and start SHALL be ignored.
REQ-027 The sample in CHECK SHALL be registered; no combinational path SHALL exist from dut_out to any output.

Reset
REQ-028 On rst=1 at a clock edge the block SHALL enter IDLE and force dut_a=0, dut_b=0, busy=0, done=0, pass=0 and fail_vec=0; reset SHALL override start and abort.
REQ-029 Reset mid-run SHALL discard the run without producing a done pulse.

Structure
REQ-030 A shared package gate_bist_pkg SHALL hold the state enum, NUM_VECTORS=4, and truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110 and TT_NAND=4'b0111.
REQ-031 The block SHALL be a single module with no sub-modules; the gate under test SHALL be external, for example the existing or_gate.

Verification
REQ-032 Scenario, correct gate: or_gate with TT_OR, SETTLE_CYCLES=2 -> done at cycle 13, pass=1, fail_vec=0000.
REQ-033 Scenario, stuck-at-0 output: dut_out tied to 0 with TT_OR -> fail_vec=1110, pass=0.
REQ-034 Scenario, wrong truth table: or_gate with TT_AND -> fail_vec=0110, pass=0.
REQ-035 Scenario, start while busy: start pulsed at cycles 1 and 6 -> exactly one done at cycle 13, and a truth_table change at cycle 6 has no effect.
REQ-036 Scenario, abort mid-run: abort at cycle 5 -> busy=0 and dut_a=dut_b=0 from cycle 6, no done, pass=0.
REQ-037 Scenario, reset mid-run: rst at cycle 7 -> all outputs at reset values next cycle; a fresh start then completes normally with pass=1.
